// File: rtl/truth_table_scanner.sv
// Exhaustive 4-input stimulus sequencer with settle delay, truth-table
// capture and comparison against an expected minterm mask.
module truth_table_scanner #(
   parameter int unsigned SETTLE = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] expected,
   input  logic        f,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] captured,
   output logic [4:0]  mismatch_cnt,
   output logic [3:0]  first_fail
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE);

   state_t      r_state, w_state_nxt;
   logic [3:0]  r_idx, w_idx_nxt;
   logic [3:0]  r_settle, w_settle_nxt;
   logic [15:0] r_exp, w_exp_nxt;
   logic [15:0] r_cap, w_cap_nxt;
   logic [4:0]  r_mcnt, w_mcnt_nxt;
   logic [3:0]  r_ff, w_ff_nxt;
   logic        r_busy, w_busy_nxt;
   logic        r_done, w_done_nxt;
   logic        w_sample;
   logic        w_miss;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_idx    <= '0;
         r_settle <= '0;
         r_exp    <= '0;
         r_cap    <= '0;
         r_mcnt   <= '0;
         r_ff     <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_idx    <= w_idx_nxt;
         r_settle <= w_settle_nxt;
         r_exp    <= w_exp_nxt;
         r_cap    <= w_cap_nxt;
         r_mcnt   <= w_mcnt_nxt;
         r_ff     <= w_ff_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
      end
   end

   assign w_sample = (r_settle == LP_SETTLE);
   assign w_miss   = (f != r_exp[r_idx]);

   always_comb begin
      w_state_nxt  = r_state;
      w_idx_nxt    = r_idx;
      w_settle_nxt = r_settle;
      w_exp_nxt    = r_exp;
      w_cap_nxt    = r_cap;
      w_mcnt_nxt   = r_mcnt;
      w_ff_nxt     = r_ff;
      w_busy_nxt   = r_busy;
      w_done_nxt   = r_done;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt  = S_RUN;
               w_idx_nxt    = '0;
               w_settle_nxt = '0;
               w_exp_nxt    = expected;
               w_cap_nxt    = '0;
               w_mcnt_nxt   = '0;
               w_ff_nxt     = '0;
               w_busy_nxt   = 1'b1;
               w_done_nxt   = 1'b0;
            end
         end
         S_RUN: begin
            if (!w_sample) begin
               w_settle_nxt = r_settle + 4'd1;
            end else begin
               w_cap_nxt[r_idx] = f;
               if (w_miss) begin
                  w_mcnt_nxt = r_mcnt + 5'd1;
                  if (r_mcnt == 5'd0) w_ff_nxt = r_idx;
               end
               // Index doubles as the applied vector, so it parks at 0 in DONE
               if (r_idx == 4'd15) begin
                  w_state_nxt = S_DONE;
                  w_idx_nxt   = '0;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_idx_nxt    = r_idx + 4'd1;
                  w_settle_nxt = '0;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign {A, B, C, D}  = r_idx;
   assign busy          = r_busy;
   assign done          = r_done;
   assign pass          = r_done & (r_mcnt == 5'd0);
   assign captured      = r_cap;
   assign mismatch_cnt  = r_mcnt;
   assign first_fail    = r_ff;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Self-checking bench: table vectors, control corner cases, random
// truth tables against a set-arithmetic reference, and a SETTLE=0 instance.
module tb_truth_table_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start2, start0;
   logic [15:0] expected;
   logic        f2, f0;
   logic        A2, B2, C2, D2, A0, B0, C0, D0;
   logic        busy2, done2, pass2, busy0, done0, pass0;
   logic [15:0] cap2, cap0;
   logic [4:0]  mc2, mc0;
   logic [3:0]  ff2, ff0;

   int errors = 0;
   int checks = 0;

   logic        use_tbl;
   logic [15:0] fn_tbl;
   logic [3:0]  vec2;

   always #5 clk = ~clk;

   truth_table_scanner #(.SETTLE(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .expected(expected),
      .f(f2), .A(A2), .B(B2), .C(C2), .D(D2), .busy(busy2),
      .done(done2), .pass(pass2), .captured(cap2),
      .mismatch_cnt(mc2), .first_fail(ff2)
   );

   truth_table_scanner #(.SETTLE(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .expected(expected),
      .f(f0), .A(A0), .B(B0), .C(C0), .D(D0), .busy(busy0),
      .done(done0), .pass(pass0), .captured(cap0),
      .mismatch_cnt(mc0), .first_fail(ff0)
   );

   assign vec2 = {A2, B2, C2, D2};
   assign f2 = use_tbl ? fn_tbl[vec2] : ((A2 & B2) | (C2 & D2));
   assign f0 = (A0 & B0) | (C0 & D0);

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic int popcnt(input logic [15:0] v);
      int n = 0;
      for (int i = 0; i < 16; i++) if (v[i]) n++;
      return n;
   endfunction

   function automatic int lowest(input logic [15:0] v);
      for (int i = 0; i < 16; i++) if (v[i]) return i;
      return 0;
   endfunction

   // Start a scan on the SETTLE=2 instance, optionally disturbing it mid-run,
   // and check the results against a model computed from the function table.
   task automatic scan(input string nm, input logic tbl,
                       input logic [15:0] fn, input logic [15:0] ex,
                       input logic disturb);
      logic [15:0] truth;
      int n;
      int miss;
      use_tbl = tbl;
      fn_tbl  = fn;
      truth   = tbl ? fn : 16'hF888;
      @(negedge clk);
      start2   = 1'b1;
      expected = ex;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (busy2 && n < 400) begin
         n++;
         if (disturb && n == 10) begin
            start2   = 1'b1;
            expected = ~ex;
         end
         if (disturb && n == 11) start2 = 1'b0;
         @(negedge clk);
      end
      miss = popcnt(truth ^ ex);
      chk({nm, " busy_cycles"}, n, 48);
      chk({nm, " done"}, done2, 1);
      chk({nm, " captured"}, cap2, truth);
      chk({nm, " mismatch_cnt"}, mc2, miss);
      if (miss != 0) chk({nm, " first_fail"}, ff2, lowest(truth ^ ex));
      chk({nm, " pass"}, pass2, miss == 0);
      chk({nm, " vec_idle"}, vec2, 0);
   endtask

   typedef struct {
      string       nm;
      logic        tbl;
      logic [15:0] fn;
      logic [15:0] ex;
   } vec_t;

   vec_t tv[5];

   initial begin
      tv[0] = '{"loopback",  1'b0, 16'h0000, 16'hF888};
      tv[1] = '{"stuck0",    1'b1, 16'h0000, 16'hF888};
      tv[2] = '{"stuck1",    1'b1, 16'hFFFF, 16'h0000};
      tv[3] = '{"loop_lsb",  1'b0, 16'h0000, 16'hF889};
      tv[4] = '{"loop_msb",  1'b0, 16'h0000, 16'h7888};

      rst_n = 1'b0; start2 = 1'b0; start0 = 1'b0;
      expected = 16'h0; use_tbl = 1'b0; fn_tbl = 16'h0;

      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start2 = ~start2;
         start0 = ~start0;
         chk("rst_busy", busy2, 0);
         chk("rst_outs", {done2, pass2, vec2, cap2, mc2, ff2}, 0);
      end
      start2 = 1'b0; start0 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_busy", busy2, 0);
      chk("idle_done", done2, 0);

      // Fixed expected results written into the table by hand
      chk("tbl_stuck0_cnt_const", popcnt(16'hF888), 7);
      for (int i = 0; i < 5; i++) scan(tv[i].nm, tv[i].tbl, tv[i].fn, tv[i].ex, 1'b0);

      scan("disturb", 1'b0, 16'h0, 16'hF888, 1'b1);

      // Start while in DONE with nonzero results clears them at once
      scan("pre_done", 1'b1, 16'hFFFF, 16'h0000, 1'b0);
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      chk("restart_done", done2, 0);
      chk("restart_busy", busy2, 1);
      chk("restart_cap", cap2, 0);
      chk("restart_cnt", mc2, 0);
      begin
         int n = 0;
         while (busy2 && n < 400) begin n++; @(negedge clk); end
         chk("restart_cycles", n, 48);
         chk("restart_cap_end", cap2, 16'hFFFF);
      end

      // Asynchronous abort at cycle 20
      use_tbl = 1'b0;
      @(negedge clk);
      start2 = 1'b1; expected = 16'hF888;
      @(negedge clk);
      start2 = 1'b0;
      repeat (19) @(negedge clk);
      chk("pre_abort_busy", busy2, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy2, 0);
      chk("abort_outs", {done2, pass2, vec2, cap2, mc2, ff2}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      scan("after_abort", 1'b0, 16'h0, 16'hF888, 1'b0);

      for (int r = 0; r < 8; r++) begin
         logic [15:0] fn, ex;
         fn = 16'($urandom);
         ex = (r % 2 == 0) ? fn ^ (16'd1 << $urandom_range(15, 0))
                           : 16'($urandom);
         scan($sformatf("rand%0d", r), 1'b1, fn, ex, 1'b0);
      end

      // SETTLE = 0: one vector per cycle
      @(negedge clk);
      start0 = 1'b1; expected = 16'hF888;
      @(negedge clk);
      start0 = 1'b0;
      for (int k = 0; k < 16; k++) begin
         chk($sformatf("s0_vec%0d", k), {A0, B0, C0, D0}, k);
         @(negedge clk);
      end
      chk("s0_done", done0, 1);
      chk("s0_busy", busy0, 0);
      chk("s0_cap", cap0, 16'hF888);
      chk("s0_pass", pass0, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Upstream stimulus-and-capture stage for the 4-input combinational lab functions. On `start` it walks the inputs `A,B,C,D` through all 16 combinations in ascending order (A = MSB, D = LSB). It holds each vector for a programmable settle time and samples the function output `f` into a 16-bit captured truth table. It compares that table against an expected minterm mask and reports pass/fail, a mismatch count and the first failing index. It drives the 4-input function block directly and consumes its `f` output, replacing hand-written exhaustive stimulus with a self-checking hardware sequencer.

## Interface
- `SETTLE`, default 2: extra hold cycles per vector before sampling; legal range 0..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a scan; honoured only in IDLE or DONE.
- `expected`  in  16  expected truth table, bit i = f for vector i; latched on accepted start.
- `f`  in  1  function output from the block under test.
- `A`, `B`, `C`, `D`  out  1 each  applied vector, registered; {A,B,C,D} = index.
- `busy`  out  1  high while a scan is running.
- `done`  out  1  high from scan completion until the next accepted start.
- `pass`  out  1  valid while done; 1 iff `mismatch_cnt` == 0.
- `captured`  out  16  sampled truth table, bit i = f sampled for vector i.
- `mismatch_cnt`  out  5  number of vectors where f != expected bit (0..16).
- `first_fail`  out  4  lowest failing index; meaningful only when `mismatch_cnt` != 0.

## Operation
- States: IDLE, RUN, DONE.
- Reset, async on `rst_n` low: state = IDLE; A..D, busy, done, pass = 0; captured = 0; mismatch_cnt = 0; first_fail = 0; index = 0; settle_cnt = 0.
- IDLE/DONE with `start` = 1 at an edge:
  - State goes to RUN; index = 0; settle_cnt = 0.
  - `expected` is latched; captured, mismatch_cnt and first_fail are cleared.
  - busy = 1; done = 0.
- RUN, each edge:
  - If settle_cnt != SETTLE: settle_cnt increments.
  - Otherwise, sample: captured[index] <= f. If f != latched expected[index], mismatch_cnt increments, and first_fail <= index if this is the first mismatch.
  - After sampling at index 15: state goes to DONE, busy = 0, done = 1, A..D return to 0.
  - After sampling at any other index: index increments and settle_cnt = 0.
- `start` during RUN is ignored. `expected` changes after the accepted start have no effect.
- DONE holds all results, and A..D = 0, until the next accepted start or reset.
- `pass` is combinational: done & (mismatch_cnt == 0).
- The mismatch count saturates naturally at 16; the 5-bit width guarantees no wrap.

## Timing
- The accepted start edge is edge 0. Vector 0 appears on A..D after edge 0.
- Each vector is held for SETTLE+1 cycles. f is sampled at the last edge of the hold.
- Vector i is applied during edges i*(SETTLE+1) .. (i+1)*(SETTLE+1)-1.
- done rises and busy falls after edge 16*(SETTLE+1); with SETTLE = 2, that is edge 48.
- Result outputs update at their sampling edge. The bench reads them only when done = 1.
- Reset mid-scan aborts immediately (asynchronous) with no partial results retained. The first edge after rst_n deasserts with start = 1 begins a fresh scan.

## Test plan
- Reset: hold rst_n = 0 with start toggling -> all outputs 0 and busy stays 0; release with start = 0 -> remains in IDLE.
- Loopback, SETTLE = 2: f = A&B | C&D modelled from A..D, expected = 16'hF888, start pulse -> busy for exactly 48 cycles, then done = 1, captured = 16'hF888, mismatch_cnt = 0, pass = 1.
- Stuck-at-0: f = 0, expected = 16'hF888 -> captured = 16'h0000, mismatch_cnt = 7, first_fail = 3, pass = 0.
- Stuck-at-1: f = 1, expected = 16'h0000 -> captured = 16'hFFFF, mismatch_cnt = 16, first_fail = 0, pass = 0.
- Control robustness:
  - A start pulse and an `expected` change mid-scan -> no effect on timing or results.
  - rst_n low at cycle 20 -> outputs clear immediately; a new start completes normally.
  - A start while in DONE -> done = 0 on the next cycle and results cleared.
- SETTLE = 0 with the loopback model -> done 16 cycles after start, A..D step every cycle, captured = 16'hF888.
